cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu.sv | 182 ++++++++++++++++++
 tb/tb_cpu.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Single-cycle RV32I core executing from a 16 KiB BIOS RAM at 0x4000_0000 that
// holds both code and data; UART pins are placeholders (TX held idle).

module cpu_bios_mem (
  input  logic        clk,
  input  logic [11:0] iaddr,
  output logic [31:0] idata,
  input  logic [11:0] daddr,
  output logic [31:0] drdata,
  input  logic        we,
  input  logic [31:0] wdata
);
  logic [31:0] mem [4096];

  assign idata  = mem[iaddr];
  assign drdata = mem[daddr];

  always_ff @(posedge clk) begin
    if (we) mem[daddr] <= wdata;
  end
endmodule

module cpu_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem [32];

  assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end
endmodule

module cpu #(
  parameter int CPU_CLOCK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic bp_enable,
  input  logic serial_in,
  output logic serial_out
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33
  } opcode_e;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst, rs1_v, rs2_v, rf_wd, dmem_rdata, dmem_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        rf_we, dmem_we, dmem_hit;
  logic        unused_bits;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  cpu_bios_mem u_bios (
    .clk    (clk),
    .iaddr  (pc_q[13:2]),
    .idata  (inst),
    .daddr  (dmem_addr[13:2]),
    .drdata (dmem_rdata),
    .we     (dmem_we & ~rst),
    .wdata  (rs2_v)
  );

  cpu_reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (inst[19:15]),
    .ra2 (inst[24:20]),
    .rd1 (rs1_v),
    .rd2 (rs2_v),
    .we  (rf_we),
    .wa  (inst[11:7]),
    .wd  (rf_wd)
  );

  always_comb begin
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'd0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    // Opcode bit 5 separates STORE (S-immediate) from LOAD (I-immediate).
    dmem_addr = rs1_v + (inst[5] ? imm_s : imm_i);
    dmem_hit  = (dmem_addr[31:14] == RESET_PC[31:14]);

    pc_d    = pc_q + 32'd4;
    rf_we   = 1'b0;
    rf_wd   = '0;
    dmem_we = 1'b0;

    case (opcode_e'(inst[6:0]))
      OP_LUI:   begin rf_we = 1'b1; rf_wd = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
      OP_JAL: begin
        rf_we = 1'b1;
        rf_wd = pc_q + 32'd4;
        pc_d  = pc_q + imm_j;
      end
      OP_JALR: if (f3 == 3'd0) begin
        rf_we = 1'b1;
        rf_wd = pc_q + 32'd4;
        pc_d  = (rs1_v + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        case (f3)
          3'd0: if (rs1_v == rs2_v) pc_d = pc_q + imm_b;
          3'd1: if (rs1_v != rs2_v) pc_d = pc_q + imm_b;
          3'd4: if ($signed(rs1_v) <  $signed(rs2_v)) pc_d = pc_q + imm_b;
          3'd5: if ($signed(rs1_v) >= $signed(rs2_v)) pc_d = pc_q + imm_b;
          3'd6: if (rs1_v <  rs2_v) pc_d = pc_q + imm_b;
          3'd7: if (rs1_v >= rs2_v) pc_d = pc_q + imm_b;
          default: ;
        endcase
      end
      OP_LOAD: if (f3 == 3'd2) begin
        rf_we = 1'b1;
        rf_wd = dmem_hit ? dmem_rdata : '0;
      end
      OP_STORE: if (f3 == 3'd2) dmem_we = dmem_hit;
      OP_IMM: begin
        rf_we = (f3 == 3'd1) ? (f7 == 7'h00)
              : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20)
              : 1'b1;
        rf_wd = alu(f3, (f3 == 3'd5) && inst[30], rs1_v, imm_i);
      end
      OP_REG: begin
        rf_we = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        rf_wd = alu(f3, inst[30], rs1_v, rs2_v);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign serial_out  = 1'b1;
  assign unused_bits = &{1'b0, bp_enable, serial_in, dmem_addr[1:0], 32'(CPU_CLOCK_FREQ)};
endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random programs, each checked cycle by
// cycle against an instruction-level RV32I model kept in the bench.

module tb_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp_enable = 1'b0;
  logic serial_in = 1'b1;
  logic serial_out;

  localparam logic [31:0] BASE = 32'h4000_0000;

  always #5 clk = ~clk;

  cpu #(.CPU_CLOCK_FREQ(50_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .bp_enable  (bp_enable),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] prog [$];
  logic [31:0] pc_trace [$];
  logic [31:0] m_mem [4096];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int f3, int rs1, int rs2, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i('h13, 0, rd, rs1, imm);
  endfunction

  // Reference ISS: executes one instruction per call.
  function automatic void m_step();
    logic [31:0] ins, a, b, v, nxt, ea, imm_i, imm_s, imm_b, imm_j, imm_u;
    logic wr, taken;
    int rd, rs1, rs2, f3, f7;
    ins   = m_mem[m_pc[13:2]];
    rd    = int'(ins[11:7]);
    rs1   = int'(ins[19:15]);
    rs2   = int'(ins[24:20]);
    f3    = int'(ins[14:12]);
    f7    = int'(ins[31:25]);
    a     = m_reg[rs1];
    b     = m_reg[rs2];
    imm_i = 32'($signed(ins) >>> 20);
    imm_s = (imm_i & ~32'h1F) | 32'(ins[11:7]);
    imm_b = {imm_i[31:12], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {imm_i[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {ins[31:12], 12'h000};
    nxt   = m_pc + 32'd4;
    wr    = 1'b0;
    v     = '0;
    taken = 1'b0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; v = imm_u; end
      7'h17: begin wr = 1'b1; v = m_pc + imm_u; end
      7'h6F: begin wr = 1'b1; v = m_pc + 32'd4; nxt = m_pc + imm_j; end
      7'h67: if (f3 == 0) begin wr = 1'b1; v = m_pc + 32'd4; nxt = (a + imm_i) & ~32'd1; end
      7'h63: begin
        case (f3)
          0: taken = (a == b);
          1: taken = (a != b);
          4: taken = ($signed(a) < $signed(b));
          5: taken = ($signed(a) >= $signed(b));
          6: taken = (a < b);
          7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) nxt = m_pc + imm_b;
      end
      7'h03: if (f3 == 2) begin
        ea = a + imm_i;
        wr = 1'b1;
        v  = (ea >= BASE && ea < BASE + 32'h4000) ? m_mem[ea[13:2]] : 32'd0;
      end
      7'h23: if (f3 == 2) begin
        ea = a + imm_s;
        if (ea >= BASE && ea < BASE + 32'h4000) m_mem[ea[13:2]] = b;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          0: v = a + imm_i;
          2: v = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
          3: v = (a < imm_i) ? 32'd1 : 32'd0;
          4: v = a ^ imm_i;
          6: v = a | imm_i;
          7: v = a & imm_i;
          1: if (f7 == 0) v = a << ins[24:20]; else wr = 1'b0;
          default: if (f7 == 0) v = a >> ins[24:20];
                   else if (f7 == 'h20) v = 32'($signed(a) >>> ins[24:20]);
                   else wr = 1'b0;
        endcase
      end
      7'h33: begin
        wr = 1'b1;
        if (f7 == 0) begin
          case (f3)
            0: v = a + b;
            1: v = a << b[4:0];
            2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: v = (a < b) ? 32'd1 : 32'd0;
            4: v = a ^ b;
            5: v = a >> b[4:0];
            6: v = a | b;
            default: v = a & b;
          endcase
        end else if (f7 == 'h20 && f3 == 0) v = a - b;
        else if (f7 == 'h20 && f3 == 5) v = 32'($signed(a) >>> b[4:0]);
        else wr = 1'b0;
      end
      default: ;
    endcase
    if (wr && rd != 0) m_reg[rd] = v;
    m_pc = nxt;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = BASE;
  endtask

  // Asserts reset between edges, loads prog into DUT and model, releases reset.
  task automatic load_prog(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, "_rst_pc"}, dut.pc_q, BASE);
    check({name, "_rst_tx"}, {31'd0, serial_out}, 32'd1);
    for (int i = 0; i < 4096; i++) begin
      m_mem[i] = (i < prog.size()) ? prog[i] : 32'd0;
      dut.u_bios.mem[i] = m_mem[i];
    end
    model_reset();
    pc_trace.delete();
    repeat (2) @(posedge clk);
    #1;
    check({name, "_rst_hold_pc"}, dut.pc_q, BASE);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cycles(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      m_step();
      pc_trace.push_back(dut.pc_q);
      check({name, "_pc"}, dut.pc_q, m_pc);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", name, i), dut.u_rf.mem[i], (i == 0) ? 32'd0 : m_reg[i]);
  endtask

  task automatic rand_instr();
    int k, rd, rs1, rs2, f3, f7;
    k   = int'($urandom_range(0, 9));
    rd  = int'($urandom_range(0, 29));
    rs1 = int'($urandom_range(0, 31));
    rs2 = int'($urandom_range(0, 31));
    f3  = int'($urandom_range(0, 7));
    case (k)
      0, 1: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 'h20 : 0;
        if ($urandom_range(0, 15) == 0) f7 = 1;
        prog.push_back(enc_r(f7, f3, rd, rs1, rs2));
      end
      2, 3: begin
        if (f3 == 1) prog.push_back(enc_i('h13, f3, rd, rs1, int'($urandom_range(0, 31))));
        else if (f3 == 5)
          prog.push_back(enc_i('h13, f3, rd, rs1,
                               int'($urandom_range(0, 31)) | ($urandom_range(0, 1) == 1 ? 'h400 : 0)));
        else prog.push_back(enc_i('h13, f3, rd, rs1, int'($urandom)));
      end
      4: prog.push_back(enc_u(($urandom_range(0, 1) == 1) ? 'h37 : 'h17, rd, int'($urandom)));
      5: begin
        case ($urandom_range(0, 5))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
        endcase
        prog.push_back(enc_b(f3, rs1, rs2, 4 * int'($urandom_range(1, 3))));
      end
      6: prog.push_back(enc_s(2, ($urandom_range(0, 3) == 0) ? 0 : 31, rs2,
                              4 * int'($urandom_range(0, 511))));
      7: prog.push_back(enc_i('h03, 2, rd, ($urandom_range(0, 3) == 0) ? 0 : 31,
                              4 * int'($urandom_range(0, 511)) + int'($urandom_range(0, 3))));
      8: begin
        if ($urandom_range(0, 1) == 1) prog.push_back(enc_j(rd, 4 * int'($urandom_range(1, 2))));
        else begin
          prog.push_back(enc_u('h17, 30, 0));
          prog.push_back(enc_i('h67, 0, rd, 30, 13));
        end
      end
      default: begin
        case ($urandom_range(0, 8))
          0: prog.push_back(enc_i('h0F, 0, rd, 0, 0));
          1: prog.push_back(32'h0000_0073);
          2: prog.push_back(32'h0010_0073);
          3: prog.push_back(enc_i('h73, 1, rd, rs1, 'h300));
          4: prog.push_back(enc_i('h03, 0, rd, 31, 0));
          5: prog.push_back(enc_s(1, 31, rs2, 8));
          6: prog.push_back(enc_i('h67, 1, rd, 0, 0));
          7: prog.push_back(enc_b(2, rs1, rs1, 8));
          default: prog.push_back(enc_i('h13, 1, rd, rs1, 'h401));
        endcase
      end
    endcase
  endtask

  initial begin
    // ADD program, then mid-run reset and rerun
    prog = '{addi(1, 0, 100), addi(2, 0, 200), enc_r(0, 0, 1, 1, 2), addi(20, 0, 1), enc_j(0, 0)};
    load_prog("add");
    run_cycles("add", 10);
    check("add_x1", dut.u_rf.mem[1], 32'd300);
    check("add_x20", dut.u_rf.mem[20], 32'd1);
    check_regs("add");

    load_prog("mid");
    run_cycles("mid", 3);
    #3;
    rst = 1'b1;
    #1;
    check("mid_async_pc", dut.pc_q, BASE);
    for (int i = 0; i < 32; i++) check($sformatf("mid_async_x%0d", i), dut.u_rf.mem[i], 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_cycles("mid_rerun", 10);
    check("mid_x1", dut.u_rf.mem[1], 32'd300);
    check("mid_x20", dut.u_rf.mem[20], 32'd1);
    check("mid_tx", {31'd0, serial_out}, 32'd1);

    // BEQ skip
    prog = '{addi(1, 0, 500), addi(2, 0, 100), enc_b(0, 2, 2, 8), addi(1, 0, 0),
             addi(20, 0, 2), enc_j(0, 0)};
    load_prog("beq");
    run_cycles("beq", 10);
    check("beq_x1", dut.u_rf.mem[1], 32'd500);
    check("beq_x2", dut.u_rf.mem[2], 32'd100);
    check("beq_x20", dut.u_rf.mem[20], 32'd2);

    // not-taken and signed/unsigned branches
    prog = '{addi(1, 0, 1), addi(2, 0, -1), enc_b(1, 0, 0, 8), addi(3, 0, 7),
             enc_b(6, 1, 2, 8), addi(4, 0, 9), enc_b(4, 2, 1, 8), addi(5, 0, 9),
             addi(20, 0, 3), enc_j(0, 0)};
    load_prog("br");
    run_cycles("br", 12);
    check("br_bne_fall_x3", dut.u_rf.mem[3], 32'd7);
    check("br_bltu_x4", dut.u_rf.mem[4], 32'd0);
    check("br_blt_x5", dut.u_rf.mem[5], 32'd0);
    check("br_x20", dut.u_rf.mem[20], 32'd3);

    // x0 write discard and JAL link/target
    prog = '{addi(0, 0, 5), addi(0, 0, 0), addi(0, 0, 0), addi(0, 0, 0),
             enc_j(5, 8), addi(6, 0, 1), addi(7, 0, 2), enc_j(0, 0)};
    load_prog("jal");
    run_cycles("jal", 8);
    check("jal_x0", dut.u_rf.mem[0], 32'd0);
    check("jal_x5", dut.u_rf.mem[5], 32'h4000_0014);
    check("jal_next_pc", pc_trace[4], 32'h4000_0018);
    check("jal_x6", dut.u_rf.mem[6], 32'd0);
    check("jal_x7", dut.u_rf.mem[7], 32'd2);

    // memory store/load, out-of-range access, ignored low address bits
    prog = '{enc_u('h37, 1, 'h40001), enc_u('h37, 2, 'hDEADC), addi(2, 2, -'h111),
             enc_s(2, 1, 2, 0), enc_i('h03, 2, 3, 1, 0), enc_i('h03, 2, 4, 0, 0),
             enc_s(2, 0, 2, 0), enc_i('h03, 2, 5, 0, 0), enc_i('h03, 2, 6, 1, 3), enc_j(0, 0)};
    load_prog("mem");
    run_cycles("mem", 12);
    check("mem_lw", dut.u_rf.mem[3], 32'hDEAD_BEEF);
    check("mem_lw_oor", dut.u_rf.mem[4], 32'd0);
    check("mem_sw_oor", dut.u_rf.mem[5], 32'd0);
    check("mem_lw_low_bits", dut.u_rf.mem[6], 32'hDEAD_BEEF);
    check("mem_word", dut.u_bios.mem[12'h400], 32'hDEAD_BEEF);

    // random programs; x31 is the data base pointer, x30 the JALR anchor
    for (int p = 0; p < 6; p++) begin
      bp_enable = 1'($urandom_range(0, 1));
      prog = '{enc_u('h37, 31, 'h40003), enc_u('h17, 30, 0)};
      for (int i = 0; i < 60; i++) rand_instr();
      prog.push_back(enc_j(0, 0));
      load_prog($sformatf("rnd%0d", p));
      run_cycles($sformatf("rnd%0d", p), 100);
      check_regs($sformatf("rnd%0d", p));
      for (int w = 'hC00; w < 'hE00; w++)
        check($sformatf("rnd%0d_mem%03h", p, w), dut.u_bios.mem[w], m_mem[w]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
